// File: rtl/mby_mc_req_arb.sv
// Round-robin arbiter sharing the MC request port between NUM_REQ bridges, with per-requester credits.
// Optional per-requester grant counters are enabled by defining MBY_MC_ARB_PERF_CNT_EN.
module mby_mc_req_arb #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned MAX_OUTST = 8,
  localparam int unsigned ID_W     = $clog2(NUM_REQ)
) (
  input  logic                      cclk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic                      mc_valid,
  input  logic                      mc_ready,
  output logic [ADDR_W-1:0]         mc_addr,
  output logic [LEN_W-1:0]          mc_len,
  output logic [ID_W-1:0]           mc_id,
  input  logic                      cpl_valid,
  input  logic [ID_W-1:0]           cpl_id,
  input  logic                      arb_en,
`ifdef MBY_MC_ARB_PERF_CNT_EN
  input  logic                      perf_clr,
  output logic [NUM_REQ*16-1:0]     grant_cnt,
`endif
  output logic                      busy,
  output logic                      cpl_err
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic {S_EMPTY = 1'b0, S_HOLD = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_outst [NUM_REQ];
  logic [ID_W-1:0]     r_last;
  logic [ADDR_W-1:0]   r_mc_addr;
  logic [LEN_W-1:0]    r_mc_len;
  logic [ID_W-1:0]     r_mc_id;
  logic                r_cpl_err;

  logic [NUM_REQ-1:0]  w_elig;
  logic [NUM_REQ-1:0]  w_nz;
  logic [NUM_REQ-1:0]  w_cpl_hit;
  logic [NUM_REQ-1:0]  w_cpl_dec;
  logic [NUM_REQ-1:0]  w_grant_vec;
  logic                w_cpl_bad;
  logic                w_found;
  logic [ID_W-1:0]     w_win;
  logic                w_slot_free;
  logic                w_grant;

  // Per-requester eligibility and completion decode
  always_comb begin
    w_elig    = '0;
    w_nz      = '0;
    w_cpl_hit = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_elig[i]    = req_valid[i] & arb_en & (r_outst[i] < CNT_W'(MAX_OUTST));
      w_nz[i]      = (r_outst[i] != '0);
      w_cpl_hit[i] = cpl_valid & (32'(cpl_id) == i);
    end
  end

  assign w_cpl_dec = w_cpl_hit & w_nz;
  assign w_cpl_bad = cpl_valid & ~(|w_cpl_dec);

  // Round-robin search starting just after the last winner
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && w_elig[(32'(r_last) + k) % NUM_REQ]) begin
        w_found = 1'b1;
        w_win   = ID_W'((32'(r_last) + k) % NUM_REQ);
      end
    end
  end

  assign w_slot_free = (r_state == S_EMPTY) | mc_ready;
  assign w_grant     = w_slot_free & w_found & ~rst;
  assign w_grant_vec = w_grant ? (NUM_REQ'(1) << w_win) : '0;

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) r_state <= S_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_grant)          w_state_nxt = S_HOLD;
    else if (w_slot_free) w_state_nxt = S_EMPTY;
  end

  always_comb begin
    mc_valid  = (r_state == S_HOLD);
    req_ready = w_grant_vec;
    busy      = (r_state == S_HOLD) | (|w_nz);
  end

  // Output holding register and round-robin pointer
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      r_mc_addr <= '0;
      r_mc_len  <= '0;
      r_mc_id   <= '0;
      r_last    <= ID_W'(NUM_REQ - 1);
      r_cpl_err <= 1'b0;
    end else begin
      if (w_grant) begin
        r_mc_addr <= req_addr[32'(w_win) * ADDR_W +: ADDR_W];
        r_mc_len  <= req_len[32'(w_win) * LEN_W +: LEN_W];
        r_mc_id   <= w_win;
        r_last    <= w_win;
      end
      if (w_cpl_bad) r_cpl_err <= 1'b1;
    end
  end

  // Credit counters; a grant and a retire in the same cycle cancel out
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) r_outst[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (w_grant_vec[i] && !w_cpl_dec[i])      r_outst[i] <= r_outst[i] + CNT_W'(1);
        else if (!w_grant_vec[i] && w_cpl_dec[i]) r_outst[i] <= r_outst[i] - CNT_W'(1);
      end
    end
  end

  assign mc_addr = r_mc_addr;
  assign mc_len  = r_mc_len;
  assign mc_id   = r_mc_id;
  assign cpl_err = r_cpl_err;

`ifdef MBY_MC_ARB_PERF_CNT_EN
  logic [15:0] r_grant_cnt [NUM_REQ];

  // Saturating grant counters; clear has priority over increment
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) r_grant_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (perf_clr)                                   r_grant_cnt[i] <= '0;
        else if (w_grant_vec[i] && r_grant_cnt[i] != 16'hFFFF) r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) grant_cnt[i*16 +: 16] = r_grant_cnt[i];
  end
`endif

endmodule

// File: tb/tb_mby_mc_req_arb.sv
// Directed and randomized bench for mby_mc_req_arb against a behavioural arbitration model.
module tb_mby_mc_req_arb;

  localparam int NREQ = 4;
  localparam int MAXO = 8;

  logic        cclk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] a [4];
  logic [7:0]  l [4];
  logic [127:0] req_addr;
  logic [31:0] req_len;
  logic        mc_valid, mc_ready;
  logic [31:0] mc_addr;
  logic [7:0]  mc_len;
  logic [1:0]  mc_id;
  logic        cpl_valid;
  logic [1:0]  cpl_id;
  logic        arb_en;
  logic        busy, cpl_err;
  logic        perf_clr;
`ifdef MBY_MC_ARB_PERF_CNT_EN
  logic [63:0] grant_cnt;
`endif

  assign req_addr = {a[3], a[2], a[1], a[0]};
  assign req_len  = {l[3], l[2], l[1], l[0]};

  mby_mc_req_arb dut (
    .cclk(cclk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .mc_valid(mc_valid), .mc_ready(mc_ready),
    .mc_addr(mc_addr), .mc_len(mc_len), .mc_id(mc_id),
    .cpl_valid(cpl_valid), .cpl_id(cpl_id),
    .arb_en(arb_en),
`ifdef MBY_MC_ARB_PERF_CNT_EN
    .perf_clr(perf_clr), .grant_cnt(grant_cnt),
`endif
    .busy(busy), .cpl_err(cpl_err)
  );

  always #5 cclk = ~cclk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit          m_valid;
  logic [31:0] m_addr;
  logic [7:0]  m_len;
  int          m_id, m_last, m_win;
  int          m_outst [4];
  int          m_gcnt [4];
  bit          m_err, m_grant;
  logic [3:0]  m_ready;
  logic [3:0]  last_gnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_busy();
    bit b = m_valid;
    for (int i = 0; i < NREQ; i++) if (m_outst[i] != 0) b = 1'b1;
    return b;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_addr = '0; m_len = '0; m_id = 0; m_last = NREQ - 1; m_err = 0;
    for (int i = 0; i < NREQ; i++) begin m_outst[i] = 0; m_gcnt[i] = 0; end
  endtask

  // Decide this cycle's winner from the current inputs
  task automatic model_comb();
    bit slot = !m_valid || mc_ready;
    m_grant = 0; m_win = 0;
    if (slot) begin
      for (int k = 1; k <= NREQ; k++) begin
        int idx = (m_last + k) % NREQ;
        if (!m_grant && req_valid[idx] && arb_en && m_outst[idx] < MAXO) begin
          m_grant = 1; m_win = idx;
        end
      end
    end
    m_ready = m_grant ? 4'(1 << m_win) : 4'b0;
  endtask

  task automatic model_clk();
    bit ok = cpl_valid && (m_outst[cpl_id] > 0);
    if (cpl_valid && !ok) m_err = 1;
    if (perf_clr) for (int i = 0; i < NREQ; i++) m_gcnt[i] = 0;
    else if (m_grant && m_gcnt[m_win] < 65535) m_gcnt[m_win]++;
    if (m_grant) begin
      m_outst[m_win]++;
      m_valid = 1; m_addr = a[m_win]; m_len = l[m_win]; m_id = m_win; m_last = m_win;
    end else if (!m_valid || mc_ready) begin
      m_valid = 0;
    end
    if (ok) m_outst[cpl_id]--;
  endtask

  // One clock: inputs already driven after a falling edge
  task automatic step();
    #1;
    model_comb();
    last_gnt = req_ready;
    chk("req_ready", 64'(req_ready), 64'(m_ready));
    @(posedge cclk);
    model_clk();
    @(negedge cclk);
    chk("mc_valid", 64'(mc_valid), 64'(m_valid));
    chk("mc_id", 64'(mc_id), 64'(m_id));
    chk("mc_addr", 64'(mc_addr), 64'(m_addr));
    chk("mc_len", 64'(mc_len), 64'(m_len));
    chk("cpl_err", 64'(cpl_err), 64'(m_err));
    chk("busy", 64'(busy), 64'(m_busy()));
`ifdef MBY_MC_ARB_PERF_CNT_EN
    for (int i = 0; i < NREQ; i++) chk("grant_cnt", 64'(grant_cnt[i*16 +: 16]), 64'(m_gcnt[i]));
`endif
  endtask

  task automatic do_reset();
    rst = 1; req_valid = '0; cpl_valid = 0; perf_clr = 0;
    #1;
    model_reset();
    chk("rst_mc_valid", 64'(mc_valid), 64'(0));
    chk("rst_mc_addr", 64'(mc_addr), 64'(0));
    chk("rst_mc_len", 64'(mc_len), 64'(0));
    chk("rst_mc_id", 64'(mc_id), 64'(0));
    chk("rst_cpl_err", 64'(cpl_err), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    @(posedge cclk);
    @(negedge cclk);
    rst = 0;
  endtask

  int g;

  initial begin
    rst = 1; req_valid = '0; mc_ready = 0; cpl_valid = 0; cpl_id = '0; arb_en = 1; perf_clr = 0;
    for (int i = 0; i < NREQ; i++) begin a[i] = 32'h1000_0000 + 32'(i * 32'h100); l[i] = 8'(i + 1); end
    do_reset();

    // All requesters, ready MC: strict rotation 0,1,2,3,0
    req_valid = 4'b1111; mc_ready = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t1_seq_id", 64'(mc_id), 64'(k % 4));
    end

    // Single requester exhausts its credits, one completion frees the next grant
    do_reset();
    req_valid = 4'b0100; mc_ready = 1; g = 0;
    for (int k = 0; k < 10; k++) begin step(); g += int'(last_gnt[2]); end
    chk("t2_grants_at_limit", 64'(g), 64'(8));
    cpl_valid = 1; cpl_id = 2'd2;
    step(); g += int'(last_gnt[2]);
    cpl_valid = 0;
    step(); g += int'(last_gnt[2]);
    chk("t2_grant_after_cpl", 64'(g), 64'(9));

    // Backpressure keeps the held request stable
    do_reset();
    a[0] = 32'h1000_0040; l[0] = 8'h03;
    req_valid = 4'b0001; mc_ready = 0;
    step();
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_hold_addr", 64'(mc_addr), 64'h1000_0040);
      chk("t3_hold_len", 64'(mc_len), 64'h03);
    end
    mc_ready = 1;
    step();
    chk("t3_next_winner", 64'(mc_id), 64'(1));

    // Simultaneous grant and completion leave the credit count unchanged
    do_reset();
    req_valid = 4'b0010; mc_ready = 1;
    for (int k = 0; k < 3; k++) step();
    cpl_valid = 1; cpl_id = 2'd1;
    step();
    req_valid = '0;
    for (int k = 0; k < 3; k++) step();
    chk("t4_three_retired_ok", 64'(cpl_err), 64'(0));
    cpl_id = 2'd3;
    step();
    cpl_valid = 0;
    step(); step();
    chk("t4_err_sticky", 64'(cpl_err), 64'(1));

    // Arbitration disabled: held request drains, busy until credits return
    do_reset();
    req_valid = 4'b0011; mc_ready = 1;
    step(); step();
    arb_en = 0;
    step();
    chk("t5_drained", 64'(mc_valid), 64'(0));
    chk("t5_busy_outst", 64'(busy), 64'(1));
    step();
    cpl_valid = 1; cpl_id = 2'd0;
    step();
    chk("t5_busy_one_left", 64'(busy), 64'(1));
    cpl_id = 2'd1;
    step();
    cpl_valid = 0;
    chk("t5_idle", 64'(busy), 64'(0));
    arb_en = 1;

`ifdef MBY_MC_ARB_PERF_CNT_EN
    do_reset();
    req_valid = 4'b0001; mc_ready = 1;
    step();
    cpl_valid = 1; cpl_id = 2'd0;
    for (int k = 0; k < 9; k++) step();
    chk("pc_ten_grants", 64'(grant_cnt[15:0]), 64'd10);
    perf_clr = 1;
    step();
    perf_clr = 0; cpl_valid = 0;
    chk("pc_clear_wins", 64'(grant_cnt[15:0]), 64'd0);
`endif

    // Randomized traffic with a mid-run asynchronous reset
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      req_valid = 4'($urandom);
      mc_ready  = ($urandom_range(0, 3) != 0);
      cpl_valid = ($urandom_range(0, 2) == 0);
      cpl_id    = 2'($urandom);
      arb_en    = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < NREQ; i++) begin a[i] = $urandom; l[i] = 8'($urandom); end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
